// File: rtl/target_feeder.sv
// target_feeder: buffers one target sequence and streams it, with boundary scores, into PE 0 of the systolic array
module target_feeder #(
    parameter int CALC_BIT = 16,
    parameter int MAX_T    = 64,
    parameter int T_AW     = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                reload_i,
    input  logic                first_pass_i,
    input  logic [CALC_BIT-1:0] alpha_i,
    input  logic [CALC_BIT-1:0] beta_i,
    input  logic                t_valid_i,
    input  logic [1:0]          t_data_i,
    input  logic                t_last_i,
    output logic                t_ready_o,
    input  logic                sp_empty_i,
    input  logic [CALC_BIT-1:0] sp_v_i,
    input  logic [CALC_BIT-1:0] sp_f_i,
    input  logic [CALC_BIT-1:0] sp_max_i,
    output logic                sp_rd_o,
    output logic [2:0]          t_o,
    output logic [CALC_BIT-1:0] v_o,
    output logic [CALC_BIT-1:0] v_a_o,
    output logic [CALC_BIT-1:0] f_b_o,
    output logic [CALC_BIT-1:0] max_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [T_AW:0]       len_o,
    output logic                ovf_o,
    output logic                und_o
);
    localparam int LW = T_AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TOKEN, S_STREAM, S_DONE} state_t;

    state_t              r_state, w_next;
    logic                r_first;
    logic [CALC_BIT-1:0] r_alpha, r_beta;
    logic [T_AW-1:0]     r_wr_idx;
    logic [T_AW:0]       r_rd_idx, r_len;
    logic [1:0]          r_buf [MAX_T];
    logic [2:0]          r_t;
    logic [CALC_BIT-1:0] r_v, r_va, r_f, r_m;
    logic                r_done, r_ovf, r_und;

    logic                w_accept, w_load_end, w_last_char, w_spill, w_und_hit, w_enter_token;
    logic [2:0]          w_t;
    logic [CALC_BIT-1:0] w_v, w_va, w_f, w_m;

    assign w_accept      = (r_state == S_LOAD) && t_valid_i;
    // a load ends on the tagged last char or when the buffer is full
    assign w_load_end    = w_accept && (t_last_i || (&r_wr_idx));
    assign w_last_char   = (r_rd_idx + LW'(1)) == r_len;
    assign w_spill       = (r_state == S_STREAM) && !r_first && !sp_empty_i;
    assign w_und_hit     = (r_state == S_STREAM) && !r_first && sp_empty_i;
    assign w_enter_token = (w_next == S_TOKEN) && (r_state != S_TOKEN);

    assign t_ready_o = (r_state == S_LOAD);
    assign sp_rd_o   = w_spill;
    assign t_o       = r_t;
    assign v_o       = r_v;
    assign v_a_o     = r_va;
    assign f_b_o     = r_f;
    assign max_o     = r_m;
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = r_done;
    assign len_o     = r_len;
    assign ovf_o     = r_ovf;
    assign und_o     = r_und;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next state and the PE-facing values to register; an empty spill head falls back to boundary scores
    always_comb begin
        w_next = r_state;
        w_t    = 3'b000;
        w_v    = '0;
        w_va   = '0;
        w_f    = '0;
        w_m    = '0;
        case (r_state)
            S_IDLE:   if (start_i) w_next = reload_i ? S_LOAD : ((r_len == '0) ? S_DONE : S_TOKEN);
            S_LOAD:   if (w_load_end) w_next = S_TOKEN;
            S_TOKEN:  w_next = S_STREAM;
            S_STREAM: if (w_last_char) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
        if (r_state == S_TOKEN) w_t = 3'b001;
        if (r_state == S_STREAM) begin
            w_t  = {1'b1, r_buf[r_rd_idx[T_AW-1:0]]};
            w_v  = w_spill ? sp_v_i   : '0;
            w_f  = w_spill ? sp_f_i   : r_beta;
            w_m  = w_spill ? sp_max_i : '0;
            w_va = w_v + r_alpha;
        end
    end

    // pass control: mode latch, load/replay indices, stored length and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first  <= 1'b0;
            r_alpha  <= '0;
            r_beta   <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_len    <= '0;
            r_ovf    <= 1'b0;
            r_und    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_first  <= first_pass_i;
                r_wr_idx <= '0;
            end
            if (w_accept) r_wr_idx <= r_wr_idx + T_AW'(1);
            if (w_load_end) begin
                r_len <= {1'b0, r_wr_idx} + LW'(1);
                r_ovf <= r_ovf | ~t_last_i;
            end
            if (w_enter_token) begin
                r_alpha <= alpha_i;
                r_beta  <= beta_i;
            end
            if (r_state == S_TOKEN) r_rd_idx <= '0;
            if (r_state == S_STREAM) r_rd_idx <= r_rd_idx + LW'(1);
            if (w_und_hit) r_und <= 1'b1;
        end
    end

    // registered outputs toward PE 0 and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t    <= '0;
            r_v    <= '0;
            r_va   <= '0;
            r_f    <= '0;
            r_m    <= '0;
            r_done <= 1'b0;
        end else begin
            r_t    <= w_t;
            r_v    <= w_v;
            r_va   <= w_va;
            r_f    <= w_f;
            r_m    <= w_m;
            r_done <= (r_state == S_DONE);
        end
    end

    // target character buffer; contents need no reset
    always_ff @(posedge clk) begin
        if (w_accept) r_buf[r_wr_idx] <= t_data_i;
    end
endmodule

// File: tb/tb_target_feeder.sv
// tb_target_feeder: directed and random passes checked against a queue-based model of the feeder
module tb_target_feeder;
    localparam int CB = 16;
    localparam int MT = 64;
    localparam int AW = 6;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start_i = 1'b0, reload_i = 1'b0, first_pass_i = 1'b0;
    logic [CB-1:0] alpha_i = '0, beta_i = '0;
    logic          t_valid_i = 1'b0, t_last_i = 1'b0;
    logic [1:0]    t_data_i = '0;
    logic          t_ready_o;
    logic          sp_empty_i = 1'b1;
    logic [CB-1:0] sp_v_i = '0, sp_f_i = '0, sp_max_i = '0;
    logic          sp_rd_o;
    logic [2:0]    t_o;
    logic [CB-1:0] v_o, v_a_o, f_b_o, max_o;
    logic          busy_o, done_o, ovf_o, und_o;
    logic [AW:0]   len_o;

    int checks = 0, errors = 0;

    typedef struct {logic [CB-1:0] v; logic [CB-1:0] f; logic [CB-1:0] m;} sp_t;
    typedef struct {logic [1:0] d; logic last;} up_t;

    sp_t        spq[$];
    up_t        upq[$];
    logic [1:0] mt[$];
    bit         m_ovf = 1'b0, m_und = 1'b0, pend = 1'b0;

    target_feeder #(.CALC_BIT(CB), .MAX_T(MT), .T_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .reload_i(reload_i), .first_pass_i(first_pass_i),
        .alpha_i(alpha_i), .beta_i(beta_i), .t_valid_i(t_valid_i), .t_data_i(t_data_i), .t_last_i(t_last_i),
        .t_ready_o(t_ready_o), .sp_empty_i(sp_empty_i), .sp_v_i(sp_v_i), .sp_f_i(sp_f_i), .sp_max_i(sp_max_i),
        .sp_rd_o(sp_rd_o), .t_o(t_o), .v_o(v_o), .v_a_o(v_a_o), .f_b_o(f_b_o), .max_o(max_o),
        .busy_o(busy_o), .done_o(done_o), .len_o(len_o), .ovf_o(ovf_o), .und_o(und_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sp();
        sp_empty_i = (spq.size() == 0);
        if (spq.size() > 0) begin
            sp_v_i = spq[0].v; sp_f_i = spq[0].f; sp_max_i = spq[0].m;
        end else begin
            sp_v_i = CB'($urandom); sp_f_i = CB'($urandom); sp_max_i = CB'($urandom);
        end
    endtask

    task automatic push_sp(input logic [CB-1:0] v, input logic [CB-1:0] f, input logic [CB-1:0] m, input int n);
        sp_t e;
        e.v = v; e.f = f; e.m = m;
        for (int i = 0; i < n; i++) spq.push_back(e);
        drive_sp();
    endtask

    task automatic push_up(input logic [1:0] d, input logic last);
        up_t u;
        u.d = d; u.last = last;
        upq.push_back(u);
    endtask

    // one clock: spill FIFO pops on edges where the DUT requested it; returns at the falling edge
    task automatic step();
        sp_t e;
        @(posedge clk);
        #1;
        if (pend && spq.size() > 0) e = spq.pop_front();
        drive_sp();
        @(negedge clk);
        pend = sp_rd_o;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_t"}, t_o, 0);
        chk({tag, "_v"}, v_o, 0);
        chk({tag, "_va"}, v_a_o, 0);
        chk({tag, "_fb"}, f_b_o, 0);
        chk({tag, "_max"}, max_o, 0);
    endtask

    task automatic run_pass(input bit reload, input bit first, input bit tog,
                            input logic [CB-1:0] al, input logic [CB-1:0] be);
        int            nacc, k, npop;
        sp_t           snap[$];
        up_t           u;
        logic [CB-1:0] ev, ef, em, eva;
        nacc = 0;
        if (reload) begin
            mt.delete();
            for (int i = 0; i < upq.size(); i++) begin
                mt.push_back(upq[i].d);
                nacc++;
                if (upq[i].last || mt.size() == MT) break;
            end
            if (!upq[nacc-1].last) m_ovf = 1'b1;
        end
        snap = spq;
        npop = first ? 0 : ((snap.size() < mt.size()) ? snap.size() : mt.size());
        if (!first && snap.size() < mt.size()) m_und = 1'b1;
        alpha_i = al; beta_i = be;
        start_i = 1'b1; reload_i = reload; first_pass_i = first;
        step();
        start_i = 1'b0; reload_i = 1'($urandom); first_pass_i = 1'($urandom);
        chk("busy", busy_o, 1);
        if (mt.size() == 0) begin
            step();
            chk("empty_done", done_o, 1);
            chk_quiet("empty");
            step();
            chk("empty_done_clr", done_o, 0);
            chk("empty_busy", busy_o, 0);
            return;
        end
        k = 0;
        while (nacc > 0) begin
            chk("ready", t_ready_o, 1);
            chk("load_t", t_o, 0);
            t_valid_i = tog ? (k % 2 == 0) : 1'b1;
            t_data_i = upq[0].d; t_last_i = upq[0].last;
            step();
            if (t_valid_i) begin
                u = upq.pop_front();
                nacc--;
            end
            k++;
        end
        t_valid_i = (upq.size() > 0);
        if (upq.size() > 0) begin
            t_data_i = upq[0].d; t_last_i = upq[0].last;
        end
        alpha_i = CB'($urandom); beta_i = CB'($urandom);
        chk("pre_token_t", t_o, 0);
        step();
        chk("token_t", t_o, 3'b001);
        chk("token_v", v_o, 0);
        chk("token_va", v_a_o, 0);
        chk("token_fb", f_b_o, 0);
        chk("token_max", max_o, 0);
        chk("stream_ready", t_ready_o, 0);
        for (int i = 0; i < mt.size(); i++) begin
            step();
            if (!first && i < snap.size()) begin
                ev = snap[i].v; ef = snap[i].f; em = snap[i].m;
            end else begin
                ev = '0; ef = be; em = '0;
            end
            eva = ev + al;
            chk("char_t", t_o, {1'b1, mt[i]});
            chk("char_v", v_o, ev);
            chk("char_va", v_a_o, eva);
            chk("char_fb", f_b_o, ef);
            chk("char_max", max_o, em);
            chk("char_done", done_o, 0);
        end
        step();
        chk("done", done_o, 1);
        chk_quiet("done");
        step();
        chk("done_clr", done_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("len", len_o, mt.size());
        chk("ovf", ovf_o, m_ovf);
        chk("und", und_o, m_und);
        chk("spill_left", spq.size(), snap.size() - npop);
        t_valid_i = 1'b0;
        upq.delete();
    endtask

    initial begin
        int n;
        bit f;
        repeat (2) @(negedge clk);
        chk_quiet("rst");
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_len", len_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_und", und_o, 0);
        chk("rst_ready", t_ready_o, 0);
        chk("rst_sprd", sp_rd_o, 0);
        rst_n = 1'b1;
        step();

        // replay with nothing stored finishes at once
        run_pass(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0004);

        // A,C,G,T first pass
        push_up(2'd0, 1'b0); push_up(2'd1, 1'b0); push_up(2'd2, 1'b0); push_up(2'd3, 1'b1);
        run_pass(1'b1, 1'b1, 1'b0, 16'hFFFD, 16'hFFFF);

        // replay fed fully from the spill FIFO
        push_sp(16'd5, 16'd2, 16'd7, 4);
        run_pass(1'b0, 1'b0, 1'b0, 16'hFFFD, 16'hFFFF);

        // spill underflow on the third char
        push_sp(16'd5, 16'd2, 16'd7, 2);
        run_pass(1'b0, 1'b0, 1'b0, 16'hFFFD, 16'hFFFF);

        // 65 chars with no last marker overflow the buffer
        for (int i = 0; i < 65; i++) push_up(2'($urandom), 1'b0);
        run_pass(1'b1, 1'b1, 1'b0, CB'($urandom), CB'($urandom));

        // gappy upstream valid, non-first pass with random spill data
        for (int i = 0; i < 10; i++) push_up(2'($urandom), i == 9);
        for (int i = 0; i < 10; i++) push_sp(CB'($urandom), CB'($urandom), CB'($urandom), 1);
        run_pass(1'b1, 1'b0, 1'b1, CB'($urandom), CB'($urandom));

        // asynchronous reset in the middle of a stream
        spq.delete(); drive_sp();
        alpha_i = 16'h0009; beta_i = 16'h0005;
        start_i = 1'b1; reload_i = 1'b0; first_pass_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("mid_token", t_o, 3'b001);
        step();
        step();
        chk("mid_char", t_o[2], 1);
        chk("mid_fb", f_b_o, 16'h0005);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst");
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_len", len_o, 0);
        chk("mid_rst_ovf", ovf_o, 0);
        chk("mid_rst_und", und_o, 0);
        mt.delete(); m_ovf = 1'b0; m_und = 1'b0; pend = 1'b0;
        repeat (2) begin
            step();
            chk("mid_no_done", done_o, 0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            step();
            chk("post_rst_done", done_o, 0);
            chk("post_rst_busy", busy_o, 0);
        end
        for (int i = 0; i < 3; i++) push_up(2'($urandom), i == 2);
        run_pass(1'b1, 1'b1, 1'b0, CB'($urandom), CB'($urandom));

        // random passes
        repeat (8) begin
            spq.delete(); drive_sp();
            f = 1'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                n = $urandom_range(1, 20);
                for (int i = 0; i < n; i++) push_up(2'($urandom), i == n - 1);
            end
            n = $urandom_range(0, 22);
            for (int i = 0; i < n; i++) push_sp(CB'($urandom), CB'($urandom), CB'($urandom), 1);
            run_pass(upq.size() > 0, f, 1'($urandom), CB'($urandom), CB'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
